// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Handshake and data bundle between the EX stage and the multi-cycle
// multiply/divide unit.
//   valid_i  : operation request
//   ready_o  : unit can accept (idle)
//   op_i     : funct3 of the M-extension instruction
//   a_i/b_i  : rs1/rs2 operands
//   flush_i  : kill the in-flight operation
//   valid_o  : one-cycle completion pulse
//   result_o : result, held until the next completion
//   busy_o   : inverse of ready_o, drives the pipeline stall
// Modports: master (pipeline side), slave (execution unit side).
// ---------------------------------------------------------------------------
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RISC-V M-extension execution unit. Multiplies go through a
// registered two-cycle path; divides use an iterative radix-2 restoring
// divider (one quotient bit per cycle) followed by a sign-fix cycle.
// Divide-by-zero and signed overflow are resolved at accept time.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave (valid_i/ready_o/op_i/a_i/b_i/flush_i/
//           valid_o/result_o/busy_o)
//
// Optional build macro MULDIV_DIV_REUSE_EN: keeps the last completed
// full-length division and answers an identical divide in one cycle.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  // Low two funct3 bits: for multiplies they select the variant, for
  // divides bit1 = remainder and bit0 = unsigned.
  logic [1:0]       op_reg, op_next;
  logic [XLEN-1:0]  a_reg, a_next;
  logic [XLEN-1:0]  b_reg, b_next;
  logic [XLEN-1:0]  quo_reg, quo_next;   // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]  rem_reg, rem_next;
  logic [XLEN-1:0]  dvs_reg, dvs_next;   // divisor magnitude
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic [XLEN-1:0]  pend_reg, pend_next; // result waiting to be presented in DONE
  logic [XLEN-1:0]  result_reg, result_next;

  logic             valid_out;
  logic [XLEN-1:0]  result_out;

  // Accept-time decode of the request
  logic            in_is_div, in_is_rem, in_signed;
  logic            in_div_zero, in_ovf, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign in_is_div   = bus.op_i[2];
  assign in_is_rem   = bus.op_i[1];
  assign in_signed   = !bus.op_i[0];
  assign in_div_zero = (bus.b_i == '0);
  assign in_ovf      = in_signed && (bus.a_i == MIN_NEG) && (bus.b_i == ALL_ONES);
  assign a_neg       = in_signed && bus.a_i[XLEN-1];
  assign b_neg       = in_signed && bus.b_i[XLEN-1];
  assign a_mag       = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag       = b_neg ? -bus.b_i : bus.b_i;

  // Multiplier: sign/zero-extend to 2*XLEN so one unsigned multiply yields
  // the correct product for every signedness combination (mod 2^(2*XLEN)).
  // MULHSU (10) and MULH (01) treat a as signed; only MULH treats b as signed.
  logic                mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0]   mul_a_ext, mul_b_ext, product;

  assign mul_a_signed = (op_reg != 2'b11);
  assign mul_b_signed = (op_reg == 2'b01);
  assign mul_a_ext    = {{XLEN{mul_a_signed & a_reg[XLEN-1]}}, a_reg};
  assign mul_b_ext    = {{XLEN{mul_b_signed & b_reg[XLEN-1]}}, b_reg};
  assign product      = mul_a_ext * mul_b_ext;

  // Restoring divider step: bring down the next dividend bit and subtract
  // the divisor when it fits. trial needs one extra bit since rem < divisor.
  logic [XLEN:0]   trial;
  logic            trial_ge;
  logic [XLEN-1:0] q_fix, r_fix;

  assign trial    = {rem_reg, quo_reg[XLEN-1]};
  assign trial_ge = (trial >= {1'b0, dvs_reg});
  assign q_fix    = neg_q_reg ? -quo_reg : quo_reg;
  assign r_fix    = neg_r_reg ? -rem_reg : rem_reg;

`ifdef MULDIV_DIV_REUSE_EN
  logic [XLEN-1:0] cache_a_reg, cache_a_next;
  logic [XLEN-1:0] cache_b_reg, cache_b_next;
  logic [XLEN-1:0] cache_q_reg, cache_q_next;
  logic [XLEN-1:0] cache_r_reg, cache_r_next;
  logic            cache_s_reg, cache_s_next;
  logic            cache_valid_reg, cache_valid_next;
  logic            full_div_reg, full_div_next; // DONE follows a full division
  logic            cache_hit;

  assign cache_hit = cache_valid_reg && (bus.a_i == cache_a_reg) &&
                     (bus.b_i == cache_b_reg) && (in_signed == cache_s_reg);
`endif

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    quo_next    = quo_reg;
    rem_next    = rem_reg;
    dvs_next    = dvs_reg;
    cnt_next    = cnt_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    pend_next   = pend_reg;
    result_next = result_reg;
    valid_out   = 1'b0;
    result_out  = result_reg;
`ifdef MULDIV_DIV_REUSE_EN
    cache_a_next     = cache_a_reg;
    cache_b_next     = cache_b_reg;
    cache_q_next     = cache_q_reg;
    cache_r_next     = cache_r_reg;
    cache_s_next     = cache_s_reg;
    cache_valid_next = cache_valid_reg;
    full_div_next    = full_div_reg;
`endif

    unique case (state_reg)
      S_IDLE: begin
        if (bus.valid_i && !bus.flush_i) begin
          op_next = bus.op_i[1:0];
          a_next  = bus.a_i;
          b_next  = bus.b_i;
          if (!in_is_div) begin
            state_next = S_MUL;
          end else if (in_div_zero) begin
            pend_next  = in_is_rem ? bus.a_i : ALL_ONES;
            state_next = S_DONE;
          end else if (in_ovf) begin
            pend_next  = in_is_rem ? '0 : bus.a_i;
            state_next = S_DONE;
`ifdef MULDIV_DIV_REUSE_EN
          end else if (cache_hit) begin
            pend_next  = in_is_rem ? cache_r_reg : cache_q_reg;
            state_next = S_DONE;
`endif
          end else begin
            quo_next   = a_mag;
            rem_next   = '0;
            dvs_next   = b_mag;
            cnt_next   = CNT_LOAD;
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            state_next = S_DIV;
          end
        end
      end

      S_MUL: begin
        pend_next  = (op_reg == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        state_next = S_DONE;
      end

      S_DIV: begin
        rem_next = trial_ge ? (trial[XLEN-1:0] - dvs_reg) : trial[XLEN-1:0];
        quo_next = {quo_reg[XLEN-2:0], trial_ge};
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = S_FIX;
        end
      end

      S_FIX: begin
        pend_next  = op_reg[1] ? r_fix : q_fix;
        state_next = S_DONE;
`ifdef MULDIV_DIV_REUSE_EN
        cache_a_next  = a_reg;
        cache_b_next  = b_reg;
        cache_s_next  = !op_reg[0];
        cache_q_next  = q_fix;
        cache_r_next  = r_fix;
        full_div_next = 1'b1;
`endif
      end

      S_DONE: begin
        valid_out   = 1'b1;
        result_out  = pend_reg;
        result_next = pend_reg;
        state_next  = S_IDLE;
`ifdef MULDIV_DIV_REUSE_EN
        if (full_div_reg) begin
          cache_valid_next = 1'b1;
        end
        full_div_next = 1'b0;
`endif
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A kill outranks whatever the active state wanted to do, including the
    // completion pulse in DONE; the visible result stays as it was.
    if (bus.flush_i && (state_reg != S_IDLE)) begin
      state_next  = S_IDLE;
      valid_out   = 1'b0;
      result_out  = result_reg;
      result_next = result_reg;
`ifdef MULDIV_DIV_REUSE_EN
      cache_valid_next = 1'b0;
      full_div_next    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      pend_reg   <= '0;
      result_reg <= '0;
`ifdef MULDIV_DIV_REUSE_EN
      cache_a_reg     <= '0;
      cache_b_reg     <= '0;
      cache_q_reg     <= '0;
      cache_r_reg     <= '0;
      cache_s_reg     <= 1'b0;
      cache_valid_reg <= 1'b0;
      full_div_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      quo_reg    <= quo_next;
      rem_reg    <= rem_next;
      dvs_reg    <= dvs_next;
      cnt_reg    <= cnt_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      pend_reg   <= pend_next;
      result_reg <= result_next;
`ifdef MULDIV_DIV_REUSE_EN
      cache_a_reg     <= cache_a_next;
      cache_b_reg     <= cache_b_next;
      cache_q_reg     <= cache_q_next;
      cache_r_reg     <= cache_r_next;
      cache_s_reg     <= cache_s_next;
      cache_valid_reg <= cache_valid_next;
      full_div_reg    <= full_div_next;
`endif
    end
  end

  assign bus.ready_o  = (state_reg == S_IDLE);
  assign bus.busy_o   = (state_reg != S_IDLE);
  assign bus.valid_o  = valid_out;
  assign bus.result_o = result_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit (XLEN=32). A monitor compares every cycle
// against an arithmetic model of the unit; the directed sequence also pins
// hand-computed results and latencies.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_DIV_REUSE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  bit          m_pending = 1'b0;
  int          m_exp_cyc = 0;
  logic [31:0] m_exp_res = '0;
  logic [31:0] m_last = '0;
  bit          m_full = 1'b0;
  logic [31:0] m_na = '0, m_nb = '0;
  bit          m_ns = 1'b0;
  bit          m_cv = 1'b0;
  logic [31:0] m_ca = '0, m_cb = '0;
  bit          m_cs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain 64-bit arithmetic for every op; signed-overflow division falls out
  // of the wider arithmetic naturally (2^31 truncates to 0x80000000, rem 0).
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (op)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * ub;
      3'd3:       p = {32'h0, a} * {32'h0, b};
      default:    p = '0;
    endcase
    case (op)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_DIV_REUSE_EN
    if (m_cv && a == m_ca && b == m_cb && (!op[0]) == m_cs) return 1;
`endif
    return 34;
  endfunction

  task automatic monitor();
    bit exp_valid;
    int lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        m_pending = 1'b0;
        m_last    = '0;
        m_cv      = 1'b0;
      end else begin
        exp_valid = m_pending && (cyc == m_exp_cyc) && !bus.flush_i;
        chk("ready_o", 32'(bus.ready_o), 32'(!m_pending));
        chk("busy_o", 32'(bus.busy_o), 32'(m_pending));
        chk("valid_o", 32'(bus.valid_o), 32'(exp_valid));
        chk("result_o", bus.result_o, exp_valid ? m_exp_res : m_last);
        if (m_pending && bus.flush_i) begin
          m_pending = 1'b0;
          m_cv      = 1'b0;
        end else if (exp_valid) begin
          m_last    = m_exp_res;
          m_pending = 1'b0;
          if (m_full) begin
            m_cv = 1'b1; m_ca = m_na; m_cb = m_nb; m_cs = m_ns;
          end
        end else if (m_pending && cyc > m_exp_cyc) begin
          m_pending = 1'b0;  // overdue; already reported above
        end else if (!m_pending && bus.valid_i && !bus.flush_i) begin
          lat       = ref_lat(bus.op_i, bus.a_i, bus.b_i);
          m_exp_res = ref_result(bus.op_i, bus.a_i, bus.b_i);
          m_exp_cyc = cyc + lat;
          m_full    = bus.op_i[2] && (lat == 34);
          m_na = bus.a_i; m_nb = bus.b_i; m_ns = !bus.op_i[0];
          m_pending = 1'b1;
        end
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!bus.ready_o && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.ready_o) chk("issue_ready_timeout", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    n = cyc;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.op_i    = 3'($urandom);
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  n, k;
    bit  got;
    issue(op, a, b, n);
    got = 1'b0;
    k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      if (bus.valid_o) got = 1'b1;
      k++;
    end
    if (!got) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_latency"}, 32'(cyc - n), 32'(lat));
      chk({name, "_result"}, bus.result_o, exp);
      $display("%s: op=%0d a=%h b=%h result=%h latency=%0d", name, op, a, b,
               bus.result_o, cyc - n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    #1 rst_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Multiplies
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
    run_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 2);
    run_op("MUL",    3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 2);
    run_op("MULH",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);

    // Divide special cases
    run_op("DIVU_by0", 3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("REMU_by0", 3'd7, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);
    run_op("DIV_by0",  3'd4, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("REM_by0",  3'd6, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 1);
    run_op("DIV_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Full divisions
    run_op("DIV_7_m2", 3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("REM_7_m2", 3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, HIT_LAT);
    run_op("DIV_m7_2", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    run_op("REM_m7_2", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, HIT_LAT);
    run_op("DIVU_m7_2", 3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34);

    // Flush of an in-flight divide at N+10
    issue(3'd5, 32'd100, 32'd7, n);
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    chk("flush_cycle", 32'(cyc - n), 32'd11);
    chk("flush_ready", 32'(bus.ready_o), 32'd1);
    chk("flush_valid", 32'(bus.valid_o), 32'd0);
    chk("flush_result", bus.result_o, 32'h7FFF_FFFC);
    run_op("MUL_3_5", 3'd0, 32'd3, 32'd5, 32'd15, 2);

    // Flush together with a request in IDLE: nothing is accepted
    @(posedge clk);
    #1;
    bus.valid_i = 1'b1; bus.flush_i = 1'b1;
    bus.op_i = 3'd0; bus.a_i = 32'd2; bus.b_i = 32'd2;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    chk("idle_flush_ready", 32'(bus.ready_o), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("idle_flush_result", bus.result_o, 32'd15);

    // Asynchronous reset in the middle of a divide
    issue(3'd5, 32'd100, 32'd7, n);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.ready_o), 32'd1);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_valid", 32'(bus.valid_o), 32'd0);
    chk("arst_result", bus.result_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("DIVU_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    run_op("REMU_100_7", 3'd7, 32'd100, 32'd7, 32'd2, HIT_LAT);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle, parametrised M-extension execution unit that replaces the single-cycle combinational multiply/divide path in the EX stage.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation through a valid/ready handshake.
- Multiplies in a registered 2-cycle path and divides with an iterative radix-2 restoring divider.
- Returns a one-cycle result pulse. The hazard unit stalls the pipeline while busy_o is high.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, width of the divider iteration counter; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  operation request.
- ready_o  output  1  unit can accept; high only in IDLE.
- op_i  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  input  XLEN  rs1 operand (after forwarding).
- b_i  input  XLEN  rs2 operand (after forwarding).
- flush_i  input  1  synchronous kill of the in-flight operation.
- valid_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  XLEN  result; holds its value until the next completion.
- busy_o  output  1  equals !ready_o.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - ready_o=1, busy_o=0, valid_o=0, result_o=0.
  - All internal registers are cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: valid_i && ready_o && !flush_i in cycle N. Operands and op are captured at the end of cycle N. Inputs are don't-care after cycle N.
- Transitions out of IDLE on accept:
  - MUL op goes to MUL.
  - Divide special case goes to DONE.
  - All other divide ops go to DIV.
- MUL state (cycle N+1):
  - Computes the 2*XLEN product with the correct signedness; MULHSU is signed a, unsigned b.
  - Selects the low half for MUL, the high half otherwise. Next state DONE.
  - MUL latency: valid_o in cycle N+2.
- DIV state:
  - Operands are converted to magnitudes, with signs recorded for DIV/REM.
  - XLEN iterations, one quotient bit per cycle, MSB first; the counter decrements from XLEN.
  - When the counter reaches 0, go to FIX.
- FIX state:
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend. Next state DONE.
  - Divide latency: valid_o in cycle N+XLEN+2 (N+34 for XLEN=32).
- Divide special cases (resolved at accept, valid_o in cycle N+1):
  - b_i==0: quotient is all ones and remainder is a_i, for both signed and unsigned ops.
  - Signed overflow (a_i == 1 followed by XLEN-1 zeros, b_i == all ones, DIV/REM only): quotient = a_i, remainder = 0.
- DONE: valid_o=1 for exactly this cycle; result_o is updated. Next state IDLE.
- Throughput: next accept no earlier than cycle N+k+1, where k is the latency. ready_o is low in DONE.
- flush_i:
  - In MUL/DIV/FIX/DONE: go to IDLE next cycle. valid_o is forced 0 that cycle and result_o is unchanged.
  - With valid_i in IDLE: flush wins and nothing is accepted.
  - In IDLE without valid_i: no effect.
- Reset mid-operation: immediate return to reset values; no valid_o.
- Arithmetic is modulo 2^XLEN. Shift amounts are not used. No exceptions are raised.

Optional Feature:
- Macro: MULDIV_DIV_REUSE_EN.
- Defined:
  - The unit keeps the last completed non-special division: a, b, signedness, quotient, remainder, and a cache_valid bit.
  - A new DIV/DIVU/REM/REMU with identical a_i, b_i and signedness (DIV/REM vs DIVU/REMU) while cache_valid=1 goes straight to DONE. valid_o comes in cycle N+1 with the cached quotient or remainder.
  - cache_valid is cleared by reset and by any flush_i while not IDLE.
  - cache_valid is set on DONE of a full-length division.
- Undefined: every non-special divide takes XLEN+2 cycles; no cache storage is instantiated.

Test Plan:
- MULHSU, a=0xFFFFFFFF, b=0x00000002, accept cycle N -> valid_o at N+2, result 0xFFFFFFFF. MULHU on the same operands -> 0x00000001. MUL -> 0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> valid_o at N+34, result 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF, also 34 cycles unless MULDIV_DIV_REUSE_EN is defined, in which case 1 cycle.
- DIVU a=0x12345678, b=0 -> valid_o at N+1, result 0xFFFFFFFF. REMU with b=0 -> 0x12345678.
- DIV a=0x80000000, b=0xFFFFFFFF -> N+1, result 0x80000000. REM on the same operands -> 0x00000000.
- Start DIVU 100/7, assert flush_i at N+10 -> IDLE at N+11, no valid_o, result_o unchanged. Next MUL 3*5 -> valid_o with result 15, two cycles after its accept.
- Deassert rst_n asynchronously at N+5 of a divide -> outputs immediately ready_o=1, valid_o=0, result_o=0. After release, DIVU 100/7 -> 14, then REMU 100/7 -> 2.
